booth_radix4_mult_seq: RTL

- Iterative radix-4 Booth multiplier for the MIPS MULT/MULTU path. It retires one Booth digit (two multiplier bits) per clock.
- Generalises the fixed combinational Booth digit selection into a parametrised, clocked unit:
  - WIDTH-bit operands
  - signed/unsigned mode per operation
  - Start/Done handshake
- The full 2*WIDTH-bit product feeds the HI/LO registers.

---
 rtl/booth_radix4_mult_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/booth_radix4_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, signed or unsigned operands.
// Optional BOOTH_ZERO_BYPASS_EN: a zero operand skips RUN and completes in one cycle.
module booth_radix4_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int PW = 2 * E + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [E-1:0]     m;
  logic [PW-1:0]    p;
  logic [CNT_W-1:0] cnt;

  logic [E-1:0]     a_ext;
  logic [E-1:0]     b_ext;
  logic [E:0]       sel;
  logic [E:0]       sum;
  logic [PW-1:0]    p_next;

  // Two extension bits keep the +/-2M partial products and the running sum from overflowing.
  always_comb begin
    a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  end

  always_comb begin
    sel = '0;
    case (p[2:0])
      3'b001, 3'b010: sel = {m[E-1], m};
      3'b011:         sel = {m, 1'b0};
      3'b100:         sel = -{m, 1'b0};
      3'b101, 3'b110: sel = -{m[E-1], m};
      default:        sel = '0;
    endcase
    sum    = {p[PW-1], p[PW-1:E+1]} + sel;
    p_next = {sum[E], sum, p[E:2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m       <= '0;
      p       <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef BOOTH_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              product <= '0;
            end else begin
`else
            begin
`endif
              m     <= a_ext;
              p     <= {{E{1'b0}}, b_ext, 1'b0};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          p   <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= p_next[2*WIDTH:1];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
